pif_xbus_master: RTL and testbench

- Initiator end of the PIF internal register bus (XI record out, XO byte in).
- Converts a simple command/response stream from the host-link front end (I2C byte decoder) into bus cycles:
  - XI_PWr write strobes;
  - sub-addressed read bursts that wait out the responder's fixed read pipeline.
- Sits between the host-link decoder and every XI-bus responder, including the ID/scratch/misc control block.

---
 rtl/pif_xbus_master_pkg.sv | 15 +
 rtl/pif_xbus_master_if.sv | 40 ++++
 rtl/pif_xbus_master.sv | 150 +++++++++++++++
 tb/tb_pif_xbus_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pif_xbus_master_pkg.sv
// pif_xbus_master_pkg: shared PIF widths, read latency and XI-bus initiator state encoding
package pif_xbus_master_pkg;
    localparam int TXA              = 3;
    localparam int TXSubA           = 3;
    localparam int I2C_DATA_BITS    = 6;
    localparam int PIF_READ_LATENCY = 5;
    localparam int PIFM_LEN_W       = 4;
    typedef enum logic [2:0] {
        PIFM_IDLE    = 3'd0,
        PIFM_WR      = 3'd1,
        PIFM_RD_WAIT = 3'd2,
        PIFM_RD_RESP = 3'd3,
        PIFM_RD_FIN  = 3'd4
    } pifm_state_e;
endpackage

// File: rtl/pif_xbus_master_if.sv
// pif_xbus_master_if: host command/response streams plus the XI/XO responder bus
// master: the bus initiator (drives cmd_ready, rsp_*, busy, XI_*; samples cmd_*, rsp_ready, XO)
// slave:  the environment side (host decoder, response sink and responders)
interface pif_xbus_master_if
    import pif_xbus_master_pkg::*;
#(
    parameter int ADDR_W = TXA + 1,
    parameter int SUBA_W = TXSubA + 1,
    parameter int DATA_W = I2C_DATA_BITS,
    parameter int LEN_W  = PIFM_LEN_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [SUBA_W-1:0] cmd_suba;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic              rsp_last;
    logic              busy;
    logic              XI_PWr;
    logic [ADDR_W-1:0] XI_PRWA;
    logic              XI_PRdFinished;
    logic [SUBA_W-1:0] XI_PRdSubA;
    logic [DATA_W-1:0] XI_PD;
    logic [7:0]        XO;
    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_suba, cmd_len, cmd_data, rsp_ready, XO,
        output cmd_ready, rsp_valid, rsp_data, rsp_last, busy,
        output XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD
    );
    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_suba, cmd_len, cmd_data, rsp_ready, XO,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last, busy,
        input  XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD
    );
endinterface

// File: rtl/pif_xbus_master.sv
// pif_xbus_master: XI-bus initiator turning host commands into write strobes and latency-timed read bursts
// Ports: xclk (clock), sys_rst (synchronous, active-low reset),
//        bus (master modport: command stream in, read bytes out, busy, XI record out, XO byte in)
module pif_xbus_master
    import pif_xbus_master_pkg::*;
#(
    parameter int ADDR_W       = TXA + 1,
    parameter int SUBA_W       = TXSubA + 1,
    parameter int DATA_W       = I2C_DATA_BITS,
    parameter int LEN_W        = PIFM_LEN_W,
    parameter int READ_LATENCY = PIF_READ_LATENCY
) (
    input  logic              xclk,
    input  logic              sys_rst,
    pif_xbus_master_if.master bus
);
    // Loaded on each address/sub-address change; capture happens on the edge after it reaches 0,
    // so XO is sampled exactly READ_LATENCY edges after the bus was driven.
    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

    pifm_state_e       state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              pwr_q, pwr_d;
    logic              fin_q, fin_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SUBA_W-1:0] suba_q, suba_d;
    logic [DATA_W-1:0] pd_q, pd_d;
    logic              accept;
    logic              handshake;

    assign accept    = bus.cmd_valid & cmd_ready_q;
    assign handshake = rsp_valid_q & bus.rsp_ready;

    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            state_q     <= PIFM_IDLE;
            wait_q      <= '0;
            rem_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            pwr_q       <= 1'b0;
            fin_q       <= 1'b0;
            addr_q      <= '0;
            suba_q      <= '0;
            pd_q        <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rem_q       <= rem_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            pwr_q       <= pwr_d;
            fin_q       <= fin_d;
            addr_q      <= addr_d;
            suba_q      <= suba_d;
            pd_q        <= pd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PIFM_IDLE:    state_d = !accept ? PIFM_IDLE : bus.cmd_rd ? PIFM_RD_WAIT : PIFM_WR;
            PIFM_WR:      state_d = PIFM_IDLE;
            PIFM_RD_WAIT: state_d = (wait_q == '0) ? PIFM_RD_RESP : PIFM_RD_WAIT;
            PIFM_RD_RESP: state_d = handshake ? PIFM_RD_FIN : PIFM_RD_RESP;
            PIFM_RD_FIN:  state_d = (rem_q == '0) ? PIFM_IDLE : PIFM_RD_WAIT;
            default:      state_d = PIFM_IDLE;
        endcase
    end

    // Every output is a flop; its next value is derived here from the current state and the
    // upcoming state so that cmd_ready/busy change on the same edge as the state itself.
    always_comb begin
        wait_d      = wait_q;
        rem_d       = rem_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        addr_d      = addr_q;
        suba_d      = suba_q;
        pd_d        = pd_q;
        pwr_d       = 1'b0;
        fin_d       = 1'b0;
        cmd_ready_d = (state_d == PIFM_IDLE);
        busy_d      = (state_d != PIFM_IDLE);
        case (state_q)
            PIFM_IDLE: begin
                if (accept) begin
                    addr_d = bus.cmd_addr;
                    if (bus.cmd_rd) begin
                        suba_d = bus.cmd_suba;
                        rem_d  = bus.cmd_len;
                        wait_d = WAIT_INIT;
                    end else begin
                        pd_d  = bus.cmd_data;
                        pwr_d = 1'b1;
                    end
                end
            end
            PIFM_RD_WAIT: begin
                if (wait_q == '0) begin
                    rsp_data_d  = bus.XO;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (rem_q == '0);
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            PIFM_RD_RESP: begin
                if (handshake) begin
                    rsp_valid_d = 1'b0;
                    fin_d       = 1'b1;
                end
            end
            PIFM_RD_FIN: begin
                // Sub-address wraps naturally at 2^SUBA_W.
                if (rem_q != '0) begin
                    rem_d  = rem_q - 1'b1;
                    suba_d = suba_q + 1'b1;
                    wait_d = WAIT_INIT;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.busy           = busy_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_last       = rsp_last_q;
    assign bus.XI_PWr         = pwr_q;
    assign bus.XI_PRWA        = addr_q;
    assign bus.XI_PRdFinished = fin_q;
    assign bus.XI_PRdSubA     = suba_q;
    assign bus.XI_PD          = pd_q;
endmodule

// File: tb/tb_pif_xbus_master.sv
// tb_pif_xbus_master: directed bench with a behavioural bus model and a 5-stage readback responder
module tb_pif_xbus_master;
    import pif_xbus_master_pkg::*;
    localparam int L = PIF_READ_LATENCY;

    logic xclk = 1'b0;
    logic sys_rst = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fin_cnt = 0;
    int last_fin_cyc = 0;
    bit started = 1'b0;

    pif_xbus_master_if bus ();
    pif_xbus_master dut (.xclk(xclk), .sys_rst(sys_rst), .bus(bus));

    always #5 xclk = ~xclk;

    // Responder: register 1 reads 0x6A, register 3 reads {6, suba}, everything else 0x00.
    function automatic logic [7:0] resp_f(input logic [3:0] a, input logic [3:0] s);
        return (a == 4'h1) ? 8'h6A : (a == 4'h3) ? {4'h6, s} : 8'h00;
    endfunction

    logic [7:0] pipe [L-1] = '{default: 8'h00};
    always @(posedge xclk) begin
        pipe[0] <= resp_f(bus.XI_PRWA, bus.XI_PRdSubA);
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.XO = pipe[L-2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: what the bus must be doing, tracked as a phase plus an age counter since the
    // sub-address was presented and a count of bytes still owed.
    typedef enum {M_IDLE, M_STROBE, M_LATENCY, M_HOLD, M_DONE} mphase_e;
    mphase_e    m_ph = M_IDLE;
    int         m_age = 0;
    int         m_left = 0;
    logic       e_pwr = 1'b0, e_fin = 1'b0, e_valid = 1'b0, e_last = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic [3:0] e_addr = 4'h0, e_suba = 4'h0;
    logic [5:0] e_pd = 6'h00;

    always @(posedge xclk) begin
        cyc++;
        started = 1'b1;
        if (!sys_rst) begin
            m_ph = M_IDLE;
            e_pwr = 1'b0; e_fin = 1'b0; e_valid = 1'b0; e_last = 1'b0;
            e_data = 8'h00; e_addr = 4'h0; e_suba = 4'h0; e_pd = 6'h00;
        end else begin
            e_pwr = 1'b0;
            e_fin = 1'b0;
            case (m_ph)
                M_IDLE: if (bus.cmd_valid) begin
                    e_addr = bus.cmd_addr;
                    if (bus.cmd_rd) begin
                        e_suba = bus.cmd_suba;
                        m_left = int'(bus.cmd_len);
                        m_age = 0;
                        m_ph = M_LATENCY;
                    end else begin
                        e_pd = bus.cmd_data;
                        e_pwr = 1'b1;
                        m_ph = M_STROBE;
                    end
                end
                M_STROBE: m_ph = M_IDLE;
                M_LATENCY: begin
                    m_age++;
                    if (m_age == L) begin
                        e_valid = 1'b1;
                        e_data = resp_f(e_addr, e_suba);
                        e_last = (m_left == 0);
                        m_ph = M_HOLD;
                    end
                end
                M_HOLD: if (bus.rsp_ready) begin
                    e_valid = 1'b0;
                    e_fin = 1'b1;
                    m_ph = M_DONE;
                end
                M_DONE: if (m_left == 0) m_ph = M_IDLE;
                        else begin
                            m_left--;
                            e_suba = e_suba + 4'd1;
                            m_age = 0;
                            m_ph = M_LATENCY;
                        end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(negedge xclk) if (started) begin
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_ph == M_IDLE));
        chk("busy", 32'(bus.busy), 32'(m_ph != M_IDLE));
        chk("XI_PWr", 32'(bus.XI_PWr), 32'(e_pwr));
        chk("XI_PRdFinished", 32'(bus.XI_PRdFinished), 32'(e_fin));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
        chk("rsp_last", 32'(bus.rsp_last), 32'(e_last));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e_data));
        chk("XI_PRWA", 32'(bus.XI_PRWA), 32'(e_addr));
        chk("XI_PRdSubA", 32'(bus.XI_PRdSubA), 32'(e_suba));
        chk("XI_PD", 32'(bus.XI_PD), 32'(e_pd));
        chk("pwr_fin_overlap", 32'(bus.XI_PWr & bus.XI_PRdFinished), 32'd0);
        if (bus.XI_PRdFinished === 1'b1) begin
            fin_cnt++;
            last_fin_cyc = cyc;
        end
    end

    task automatic drive_cmd(input bit rd, input logic [3:0] a, input logic [3:0] s,
                             input logic [3:0] len, input logic [5:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_addr  = a;
        bus.cmd_suba  = s;
        bus.cmd_len   = len;
        bus.cmd_data  = d;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge xclk);
            n++;
        end
        if (n >= 40) chk({name, "_timeout"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    logic [7:0] burst_bytes [3] = '{8'h6E, 8'h6F, 8'h60};
    logic [3:0] burst_subas [3] = '{4'hE, 4'hF, 4'h0};

    initial begin
        int n;
        int fin0;
        bus.rsp_ready = 1'b1;
        drive_cmd(1'b0, 4'h5, 4'h0, 4'h0, 6'h11);
        sys_rst = 1'b0;
        repeat (3) @(posedge xclk);
        @(negedge xclk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_pwr", 32'(bus.XI_PWr), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_prwa", 32'(bus.XI_PRWA), 32'd0);
        sys_rst = 1'b1;
        @(negedge xclk);
        chk("first_accept_pwr", 32'(bus.XI_PWr), 32'd1);
        chk("first_accept_prwa", 32'(bus.XI_PRWA), 32'h5);
        bus.cmd_valid = 1'b0;
        @(negedge xclk);
        chk("first_accept_once", 32'(bus.XI_PWr), 32'd0);
        @(negedge xclk);

        drive_cmd(1'b0, 4'h2, 4'h9, 4'h7, 6'h2A);
        @(negedge xclk);
        bus.cmd_valid = 1'b0;
        chk("wr_pwr", 32'(bus.XI_PWr), 32'd1);
        chk("wr_prwa", 32'(bus.XI_PRWA), 32'h2);
        chk("wr_pd", 32'(bus.XI_PD), 32'h2A);
        chk("wr_busy", 32'(bus.busy), 32'd1);
        @(negedge xclk);
        chk("wr_pwr_end", 32'(bus.XI_PWr), 32'd0);
        chk("wr_ready_back", 32'(bus.cmd_ready), 32'd1);

        drive_cmd(1'b1, 4'h1, 4'h1, 4'h0, 6'h3F);
        @(negedge xclk);
        bus.cmd_valid = 1'b0;
        wait_valid("rd", n);
        chk("rd_latency", 32'(n), 32'(L));
        chk("rd_data", 32'(bus.rsp_data), 32'h6A);
        chk("rd_last", 32'(bus.rsp_last), 32'd1);
        @(negedge xclk);
        chk("rd_fin", 32'(bus.XI_PRdFinished), 32'd1);
        chk("rd_valid_drop", 32'(bus.rsp_valid), 32'd0);
        @(negedge xclk);
        chk("rd_fin_end", 32'(bus.XI_PRdFinished), 32'd0);
        chk("rd_idle", 32'(bus.cmd_ready), 32'd1);

        fin0 = fin_cnt;
        drive_cmd(1'b1, 4'h3, 4'hE, 4'h2, 6'h00);
        @(negedge xclk);
        bus.cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wait_valid("burst", n);
            chk("burst_data", 32'(bus.rsp_data), 32'(burst_bytes[b]));
            chk("burst_suba", 32'(bus.XI_PRdSubA), 32'(burst_subas[b]));
            chk("burst_last", 32'(bus.rsp_last), 32'(b == 2));
            if (b == 1) begin
                bus.rsp_ready = 1'b0;
                repeat (4) begin
                    @(negedge xclk);
                    chk("bp_data", 32'(bus.rsp_data), 32'h6F);
                    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
                    chk("bp_fin", 32'(bus.XI_PRdFinished), 32'd0);
                end
                bus.rsp_ready = 1'b1;
            end
            @(negedge xclk);
            chk("burst_fin", 32'(bus.XI_PRdFinished), 32'd1);
        end
        @(negedge xclk);
        chk("burst_fin_count", 32'(fin_cnt - fin0), 32'd3);

        drive_cmd(1'b1, 4'h3, 4'h0, 4'h3, 6'h00);
        @(negedge xclk);
        bus.cmd_valid = 1'b0;
        wait_valid("rst_burst", n);
        @(negedge xclk);
        chk("rst_burst_fin1", 32'(bus.XI_PRdFinished), 32'd1);
        repeat (2) @(negedge xclk);
        sys_rst = 1'b0;
        @(negedge xclk);
        sys_rst = 1'b1;
        fin0 = fin_cnt;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_prwa", 32'(bus.XI_PRWA), 32'd0);
        repeat (15) @(negedge xclk);
        chk("midrst_no_fin", 32'(fin_cnt - fin0), 32'd0);
        chk("midrst_no_valid", 32'(bus.rsp_valid), 32'd0);
        drive_cmd(1'b0, 4'h4, 4'h0, 4'h0, 6'h15);
        @(negedge xclk);
        bus.cmd_valid = 1'b0;
        chk("post_rst_pwr", 32'(bus.XI_PWr), 32'd1);
        chk("post_rst_prwa", 32'(bus.XI_PRWA), 32'h4);
        chk("post_rst_pd", 32'(bus.XI_PD), 32'h15);
        repeat (2) @(negedge xclk);

        fin0 = fin_cnt;
        drive_cmd(1'b1, 4'h3, 4'h5, 4'h1, 6'h00);
        @(negedge xclk);
        drive_cmd(1'b0, 4'h7, 4'h0, 4'h0, 6'h3C);
        n = 0;
        while (bus.XI_PWr !== 1'b1 && n < 60) begin
            @(negedge xclk);
            n++;
        end
        if (n >= 60) chk("queued_timeout", 32'(bus.XI_PWr), 32'd1);
        bus.cmd_valid = 1'b0;
        chk("queued_gap", 32'(cyc - last_fin_cyc), 32'd2);
        chk("queued_fin_count", 32'(fin_cnt - fin0), 32'd2);
        chk("queued_prwa", 32'(bus.XI_PRWA), 32'h7);
        chk("queued_pd", 32'(bus.XI_PD), 32'h3C);
        repeat (3) @(negedge xclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
